arrow_spawner: RTL and testbench
================================

Name: arrow_spawner

Overview:
- Upstream stage of the arrow sprite/trajectory blocks. Owns NUM_ARROWS arrow slots and drives each slot's valid/speed/direction/inversed/next controls.
- Schedules spawns once per video frame using a 16-bit LFSR. Raises difficulty by level. Retires a slot when its arrow reports is_hit.
- Sits between game-state control and the bank of arrow instances.

Parameters:
- NUM_ARROWS, 4, number of arrow slots (1..8).
- GAP_FRAMES, 30, base frames between spawns at level 0.
- MIN_GAP, 8, floor on the spawn gap in frames.
- ARROWS_PER_LEVEL, 8, spawns per level before the level increments.
- BASE_SPEED, 2, speed at level 0 (pixels/frame).
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- hcount_in  in  11  pixel column
- vcount_in  in  10  pixel row
- start_in  in  1  level-sensitive; leaves IDLE
- game_over_in  in  1  forces a return to IDLE, all slots cleared
- is_hit_in  in  NUM_ARROWS  per-slot one-cycle hit pulse from the arrow blocks
- valid_out  out  NUM_ARROWS  per-slot arrow active
- speed_out  out  3*NUM_ARROWS  per-slot speed; slot i at [3i+2:3i]
- direction_out  out  2*NUM_ARROWS  per-slot direction; 00 top, 01 bottom, 10 left-entry, 11 right-entry
- inversed_out  out  NUM_ARROWS  per-slot inverse-trajectory enable
- next_out  out  NUM_ARROWS  one-hot flag on the oldest active slot; all zero if none active
- level_out  out  3  current level, 0..5
- spawn_count_out  out  8  total spawns since start, wraps at 256

Behaviour:
- Frame tick: ft = (hcount_in==0 && vcount_in==0). All scheduling, aging and the LFSR advance only on ft.
- Reset values:
  - valid_out, speed_out, direction_out, inversed_out, next_out, level_out, spawn_count_out = 0.
  - FSM = IDLE; lfsr = LFSR_SEED.
- LFSR: Galois, taps 16,14,13,11. Each ft: lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0).
- FSM states:
  - IDLE: all outputs held at reset values. start_in=1 -> GAP, with gap_cnt loaded from the gap formula.
  - GAP: on each ft, gap_cnt decrements. When gap_cnt is 1 at an ft -> SPAWN.
  - SPAWN: on the next ft, select the lowest-index slot that is free.
    - If a free slot exists, spawn into it and go to GAP.
    - If none is free, remain in SPAWN and retry each ft.
  - game_over_in=1 in any state -> IDLE next cycle, all slots cleared.
- Gap formula: gap = max(GAP_FRAMES - 4*level, MIN_GAP), computed in 8 bits.
- Spawn into slot s, registered one cycle after the ft:
  - valid[s] <= 1.
  - direction[s] <= lfsr[1:0], sampled before this ft's LFSR update.
  - inversed[s] <= lfsr[2] & (level >= 2).
  - speed[s] <= BASE_SPEED + level, saturating at 7.
  - age[s] <= 0; spawn_count increments.
- Hold rule: speed, direction and inversed of a slot are stable for the whole time valid[s]=1, because the arrow block reads them every frame.
- Retire: is_hit_in[s]=1 while valid[s]=1 -> valid[s] <= 0 next cycle. The slot then enters cooldown.
  - Cooldown ends at the first ft after the retire. This guarantees valid stays low across at least one arrow-block frame update, so the next spawn is seen as a rising edge.
  - is_hit_in on an inactive slot is ignored.
- Simultaneous retire and spawn in the same cycle: the retiring slot is not free (cooldown), so it is never chosen.
- Level: when spawn_count within the level reaches ARROWS_PER_LEVEL, level increments and the per-level counter clears. Level saturates at 5.
- Aging: each ft, age[s] increments (saturating at 255) for every active slot.
- next_out: one-hot on the active slot with the largest age; ties go to the lowest index. Combinational from registered state.
- Reset mid-operation: same as the reset values next cycle; the LFSR reloads the seed.

Test Plan:
- Basic spawn: rst, start_in=1, ft every 100 clk, seed ACE1 -> first spawn in slot 0 at the 30th ft. direction=01, inversed=0, speed=2, next_out=0001.
- Retire and cooldown: pulse is_hit_in[0] 5 clk after the spawn -> valid[0]=0 next clk. With one slot, the next spawn is not into slot 0 before the following ft; valid[0] stays low for ≥1 ft.
- All slots busy: NUM_ARROWS=4, no hits -> after 4 spawns the FSM stays in SPAWN. A hit on slot 2 -> respawn into slot 2 on the second ft after the hit.
- Level ramp: after 16 spawns -> level_out=2, speed=4, gap=22 frames, inversed_out follows lfsr[2]. After 40 spawns, level_out stays 5 and speed=7.
- next_out ordering: spawns into slots 0,1,2, then hit slot 0 -> next_out moves 0001→0010 one clk after valid[0] falls.
- game_over_in and reset mid-run: assert game_over_in with 3 slots active -> valid_out=0 and level_out=0 next clk. rst with 2 active -> same, and the first spawn after restart matches the basic spawn scenario.

Source files
------------

// File: rtl/arrow_spawner_if.sv
// Control bundle between the arrow spawner, game-state control and the arrow instance bank.
interface arrow_spawner_if #(
  parameter int NUM_ARROWS = 4
) ();
  logic [10:0]               hcount_in;
  logic [9:0]                vcount_in;
  logic                      start_in;
  logic                      game_over_in;
  logic [NUM_ARROWS-1:0]     is_hit_in;
  logic [NUM_ARROWS-1:0]     valid_out;
  logic [3*NUM_ARROWS-1:0]   speed_out;
  logic [2*NUM_ARROWS-1:0]   direction_out;
  logic [NUM_ARROWS-1:0]     inversed_out;
  logic [NUM_ARROWS-1:0]     next_out;
  logic [2:0]                level_out;
  logic [7:0]                spawn_count_out;

  modport master (
    output hcount_in, vcount_in, start_in, game_over_in, is_hit_in,
    input  valid_out, speed_out, direction_out, inversed_out, next_out,
           level_out, spawn_count_out
  );

  modport slave (
    input  hcount_in, vcount_in, start_in, game_over_in, is_hit_in,
    output valid_out, speed_out, direction_out, inversed_out, next_out,
           level_out, spawn_count_out
  );
endinterface

// File: rtl/arrow_spawner.sv
// Per-frame arrow spawn scheduler: LFSR-driven direction/inverse, level ramp, slot retire with cooldown.
//   state   | meaning
//   S_IDLE  | game not running, all slots cleared, waiting for start_in
//   S_GAP   | counting frames down to the next spawn
//   S_SPAWN | spawn due; place into lowest free slot at the next frame tick, retry while all busy
module arrow_spawner #(
  parameter int          NUM_ARROWS       = 4,
  parameter int          GAP_FRAMES       = 30,
  parameter int          MIN_GAP          = 8,
  parameter int          ARROWS_PER_LEVEL = 8,
  parameter int          BASE_SPEED       = 2,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  arrow_spawner_if.slave bus
);

  localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  GAP8  = 8'(GAP_FRAMES);
  localparam logic [7:0]  MIN8  = 8'(MIN_GAP);
  localparam logic [7:0]  APL8  = 8'(ARROWS_PER_LEVEL);
  localparam logic [2:0]  MAX_LEVEL = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_SPAWN
  } state_t;

  state_t                       state_q, state_d;
  logic [7:0]                   gap_cnt_q, gap_cnt_d;
  logic [15:0]                  lfsr_q, lfsr_d;
  logic [NUM_ARROWS-1:0]        valid_q, valid_d;
  logic [NUM_ARROWS-1:0]        cool_q, cool_d;
  logic [NUM_ARROWS-1:0]        inv_q, inv_d;
  logic [3*NUM_ARROWS-1:0]      speed_q, speed_d;
  logic [2*NUM_ARROWS-1:0]      dir_q, dir_d;
  logic [NUM_ARROWS-1:0][7:0]   age_q, age_d;
  logic [2:0]                   level_q, level_d;
  logic [7:0]                   lvl_cnt_q, lvl_cnt_d;
  logic [7:0]                   spawn_cnt_q, spawn_cnt_d;

  logic                         ft;
  logic [NUM_ARROWS-1:0]        hit;
  logic [NUM_ARROWS-1:0]        free;
  logic                         found;
  int                           sel;
  logic [2:0]                   level_nxt;
  logic [3:0]                   spd_sum;
  logic [2:0]                   spawn_spd;
  logic [NUM_ARROWS-1:0]        next_v;
  logic [7:0]                   best_age;
  logic                         any_active;

  function automatic logic [7:0] gap_of(input logic [2:0] lvl);
    logic [7:0] dec;
    logic [7:0] g;
    dec = {3'b000, lvl, 2'b00};
    g   = (dec >= GAP8) ? 8'd0 : (GAP8 - dec);
    return (g < MIN8) ? MIN8 : g;
  endfunction

  assign ft        = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
  assign hit       = bus.is_hit_in & valid_q;
  // A slot in cooldown stays unavailable until the frame tick after its retire.
  assign free      = ~valid_q & ~cool_q;
  assign spd_sum   = 4'(BASE_SPEED) + {1'b0, level_q};
  assign spawn_spd = (spd_sum > 4'd7) ? 3'd7 : spd_sum[2:0];

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    lfsr_d      = lfsr_q;
    valid_d     = valid_q & ~hit;
    cool_d      = ft ? hit : (cool_q | hit);
    inv_d       = inv_q;
    speed_d     = speed_q;
    dir_d       = dir_q;
    age_d       = age_q;
    level_d     = level_q;
    lvl_cnt_d   = lvl_cnt_q;
    spawn_cnt_d = spawn_cnt_q;
    level_nxt   = level_q;
    found       = 1'b0;
    sel         = 0;

    if (ft) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      for (int i = 0; i < NUM_ARROWS; i++) begin
        if (valid_q[i] && (age_q[i] != 8'hFF)) age_d[i] = age_q[i] + 8'd1;
      end
    end

    for (int i = NUM_ARROWS - 1; i >= 0; i--) begin
      if (free[i]) begin
        found = 1'b1;
        sel   = i;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start_in) begin
          state_d   = S_GAP;
          gap_cnt_d = gap_of(level_q);
        end
      end
      S_GAP: begin
        // Terminal count at 2 so the spawn lands exactly 'gap' frames after the previous one.
        if (ft) begin
          gap_cnt_d = gap_cnt_q - 8'd1;
          if (gap_cnt_q <= 8'd2) state_d = S_SPAWN;
        end
      end
      S_SPAWN: begin
        if (ft && found) begin
          valid_d[sel]         = 1'b1;
          speed_d[3*sel +: 3]  = spawn_spd;
          dir_d[2*sel +: 2]    = lfsr_q[1:0];
          inv_d[sel]           = lfsr_q[2] & (level_q >= 3'd2);
          age_d[sel]           = 8'd0;
          spawn_cnt_d          = spawn_cnt_q + 8'd1;
          if (lvl_cnt_q + 8'd1 == APL8) begin
            lvl_cnt_d = 8'd0;
            if (level_q != MAX_LEVEL) level_nxt = level_q + 3'd1;
          end else begin
            lvl_cnt_d = lvl_cnt_q + 8'd1;
          end
          level_d   = level_nxt;
          gap_cnt_d = gap_of(level_nxt);
          state_d   = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.game_over_in) begin
      state_d     = S_IDLE;
      gap_cnt_d   = 8'd0;
      valid_d     = '0;
      cool_d      = '0;
      inv_d       = '0;
      speed_d     = '0;
      dir_d       = '0;
      age_d       = '0;
      level_d     = 3'd0;
      lvl_cnt_d   = 8'd0;
      spawn_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= 8'd0;
      lfsr_q      <= SEED;
      valid_q     <= '0;
      cool_q      <= '0;
      inv_q       <= '0;
      speed_q     <= '0;
      dir_q       <= '0;
      age_q       <= '0;
      level_q     <= 3'd0;
      lvl_cnt_q   <= 8'd0;
      spawn_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      lfsr_q      <= lfsr_d;
      valid_q     <= valid_d;
      cool_q      <= cool_d;
      inv_q       <= inv_d;
      speed_q     <= speed_d;
      dir_q       <= dir_d;
      age_q       <= age_d;
      level_q     <= level_d;
      lvl_cnt_q   <= lvl_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
    end
  end

  // Oldest active slot; strict compare keeps ties on the lowest index.
  always_comb begin
    next_v     = '0;
    best_age   = 8'd0;
    any_active = 1'b0;
    for (int i = 0; i < NUM_ARROWS; i++) begin
      if (valid_q[i] && (!any_active || (age_q[i] > best_age))) begin
        any_active = 1'b1;
        best_age   = age_q[i];
        next_v     = '0;
        next_v[i]  = 1'b1;
      end
    end
  end

  assign bus.valid_out       = valid_q;
  assign bus.speed_out       = speed_q;
  assign bus.direction_out   = dir_q;
  assign bus.inversed_out    = inv_q;
  assign bus.next_out        = next_v;
  assign bus.level_out       = level_q;
  assign bus.spawn_count_out = spawn_cnt_q;

endmodule

// File: tb/tb_arrow_spawner.sv
// Bench for arrow_spawner: directed scenarios, a slot-occupancy table and a randomized run against a frame-level model.
module tb_arrow_spawner;

  localparam int          NA         = 4;
  localparam int          GAP_FRAMES = 30;
  localparam int          MIN_GAP    = 8;
  localparam int          APL        = 8;
  localparam int          BASE_SPEED = 2;
  localparam logic [15:0] SEED       = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  arrow_spawner_if #(.NUM_ARROWS(NA)) bus ();

  arrow_spawner #(
    .NUM_ARROWS(NA), .GAP_FRAMES(GAP_FRAMES), .MIN_GAP(MIN_GAP),
    .ARROWS_PER_LEVEL(APL), .BASE_SPEED(BASE_SPEED), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: slot occupancy plus "frames until the next spawn attempt".
  logic [NA-1:0] m_act, m_cool;
  int            m_spd[NA], m_dir[NA], m_inv[NA], m_age[NA];
  bit            m_run;
  int            m_due, m_lvl, m_inlvl, m_cnt;
  logic [15:0]   m_lfsr;

  function automatic int gap_frames(input int lvl);
    int g;
    g = GAP_FRAMES - 4 * lvl;
    return (g < MIN_GAP) ? MIN_GAP : g;
  endfunction

  task automatic model_clear();
    m_act = '0;
    m_cool = '0;
    for (int i = 0; i < NA; i++) begin
      m_spd[i] = 0; m_dir[i] = 0; m_inv[i] = 0; m_age[i] = 0;
    end
    m_run = 0; m_due = 0; m_lvl = 0; m_inlvl = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic          ftv;
    logic [15:0]   l0;
    logic [NA-1:0] act0, cool0, hits;
    int            s;
    ftv = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
    l0  = m_lfsr;
    if (rst) begin
      model_clear();
      m_lfsr = SEED;
      return;
    end
    if (ftv) m_lfsr = (l0 >> 1) ^ (l0[0] ? 16'hB400 : 16'h0000);
    if (bus.game_over_in) begin
      model_clear();
      return;
    end
    act0  = m_act;
    cool0 = m_cool;
    hits  = bus.is_hit_in & act0;
    for (int i = 0; i < NA; i++) begin
      if (ftv && act0[i] && m_age[i] < 255) m_age[i]++;
      if (hits[i]) m_act[i] = 1'b0;
      if (ftv) m_cool[i] = hits[i];
      else if (hits[i]) m_cool[i] = 1'b1;
    end
    if (!m_run) begin
      if (bus.start_in) begin
        m_run = 1;
        m_due = gap_frames(m_lvl);
      end
    end else if (ftv) begin
      m_due--;
      if (m_due <= 0) begin
        m_due = 0;
        s = -1;
        for (int i = NA - 1; i >= 0; i--) if (!act0[i] && !cool0[i]) s = i;
        if (s >= 0) begin
          m_act[s] = 1'b1;
          m_dir[s] = int'(l0[1:0]);
          m_inv[s] = (m_lvl >= 2) ? int'(l0[2]) : 0;
          m_spd[s] = (BASE_SPEED + m_lvl > 7) ? 7 : BASE_SPEED + m_lvl;
          m_age[s] = 0;
          m_cnt    = (m_cnt + 1) % 256;
          m_inlvl++;
          if (m_inlvl == APL) begin
            m_inlvl = 0;
            if (m_lvl < 5) m_lvl++;
          end
          m_due = gap_frames(m_lvl);
        end
      end
    end
  endtask

  function automatic logic [63:0] model_pack();
    logic [3*NA-1:0] sp;
    logic [2*NA-1:0] dr;
    logic [NA-1:0]   iv, nx;
    int              best;
    sp = '0; dr = '0; iv = '0; nx = '0; best = -1;
    for (int i = 0; i < NA; i++) begin
      if (m_act[i]) begin
        sp[3*i +: 3] = 3'(m_spd[i]);
        dr[2*i +: 2] = 2'(m_dir[i]);
        iv[i]        = m_inv[i][0];
      end else begin
        sp[3*i +: 3] = 3'(m_spd[i]);
        dr[2*i +: 2] = 2'(m_dir[i]);
        iv[i]        = m_inv[i][0];
      end
      if (m_act[i] && (best < 0 || m_age[i] > m_age[best])) best = i;
    end
    if (best >= 0) nx[best] = 1'b1;
    return {21'd0, m_act, sp, dr, iv, nx, 3'(m_lvl), 8'(m_cnt)};
  endfunction

  function automatic logic [63:0] dut_pack();
    return {21'd0, bus.valid_out, bus.speed_out, bus.direction_out, bus.inversed_out,
            bus.next_out, bus.level_out, bus.spawn_count_out};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) begin
      bus.hcount_in = 11'($urandom_range(1, 2047)); bus.vcount_in = 10'd0;
    end else if (r == 1) begin
      bus.hcount_in = 11'd0; bus.vcount_in = 10'($urandom_range(1, 1023));
    end else begin
      bus.hcount_in = 11'($urandom_range(1, 2047)); bus.vcount_in = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("cycle_outputs", dut_pack(), model_pack());
  endtask

  task automatic cycle_idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      step();
    end
  endtask

  task automatic ft_cycle();
    bus.hcount_in = 11'd0;
    bus.vcount_in = 10'd0;
    step();
  endtask

  task automatic frames(input int n, input int len);
    for (int i = 0; i < n; i++) begin
      ft_cycle();
      cycle_idle(len - 1);
    end
  endtask

  task automatic pulse_hit(input logic [NA-1:0] mask);
    bus.is_hit_in = mask;
    drive_idle();
    step();
    bus.is_hit_in = '0;
  endtask

  typedef struct {
    int            frames;
    logic [NA-1:0] hit;
    logic [NA-1:0] exp_valid;
    logic [NA-1:0] exp_next;
    logic [NA-1:0] exp_valid_after;
    logic [NA-1:0] exp_next_after;
  } row_t;

  row_t rows[9];
  int   sf[0:63];

  initial begin
    int            fidx;
    int            prev;
    int            c;
    logic [NA-1:0] mm;

    rows[0] = '{30, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    rows[1] = '{30, 4'b0000, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
    rows[2] = '{30, 4'b0000, 4'b0111, 4'b0001, 4'b0000, 4'b0000};
    rows[3] = '{30, 4'b0000, 4'b1111, 4'b0001, 4'b0000, 4'b0000};
    rows[4] = '{30, 4'b0100, 4'b1111, 4'b0001, 4'b1011, 4'b0001};
    rows[5] = '{ 1, 4'b0000, 4'b1011, 4'b0001, 4'b0000, 4'b0000};
    rows[6] = '{ 1, 4'b0001, 4'b1111, 4'b0001, 4'b1110, 4'b0010};
    rows[7] = '{29, 4'b0000, 4'b1110, 4'b0010, 4'b0000, 4'b0000};
    rows[8] = '{ 1, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 4'b0000};

    rst = 1'b1;
    bus.start_in = 1'b0;
    bus.game_over_in = 1'b0;
    bus.is_hit_in = '0;
    m_lfsr = SEED;
    model_clear();
    cycle_idle(2);
    rst = 1'b0;
    cycle_idle(1);
    check("reset_valid", 64'(bus.valid_out), 64'd0);
    check("reset_speed", 64'(bus.speed_out), 64'd0);
    check("reset_dir", 64'(bus.direction_out), 64'd0);
    check("reset_inv", 64'(bus.inversed_out), 64'd0);
    check("reset_next", 64'(bus.next_out), 64'd0);
    check("reset_level", 64'(bus.level_out), 64'd0);
    check("reset_count", 64'(bus.spawn_count_out), 64'd0);

    // Basic spawn with 100-clock frames.
    bus.start_in = 1'b1;
    cycle_idle(1);
    frames(29, 100);
    check("pre_spawn_valid", 64'(bus.valid_out), 64'd0);
    ft_cycle();
    check("spawn_valid", 64'(bus.valid_out), 64'b0001);
    check("spawn_dir", 64'(bus.direction_out[1:0]), 64'b01);
    check("spawn_inv", 64'(bus.inversed_out[0]), 64'd0);
    check("spawn_speed", 64'(bus.speed_out[2:0]), 64'd2);
    check("spawn_next", 64'(bus.next_out), 64'b0001);
    check("spawn_count", 64'(bus.spawn_count_out), 64'd1);
    cycle_idle(4);
    pulse_hit(4'b0001);
    check("retire_valid", 64'(bus.valid_out), 64'd0);
    check("retire_next", 64'(bus.next_out), 64'd0);
    cycle_idle(94);
    frames(1, 100);
    check("cooldown_low", 64'(bus.valid_out), 64'd0);

    // Three active, then game over.
    frames(89, 10);
    check("three_active", 64'(bus.valid_out), 64'b0111);
    bus.start_in = 1'b0;
    bus.game_over_in = 1'b1;
    drive_idle();
    step();
    bus.game_over_in = 1'b0;
    check("gameover_valid", 64'(bus.valid_out), 64'd0);
    check("gameover_level", 64'(bus.level_out), 64'd0);
    check("gameover_count", 64'(bus.spawn_count_out), 64'd0);
    check("gameover_next", 64'(bus.next_out), 64'd0);
    frames(5, 10);
    check("idle_hold", 64'(bus.valid_out), 64'd0);

    // Reset mid-run with two active; restart must reproduce the basic spawn.
    bus.start_in = 1'b1;
    cycle_idle(1);
    frames(60, 10);
    check("two_active", 64'(bus.valid_out), 64'b0011);
    rst = 1'b1;
    drive_idle();
    step();
    rst = 1'b0;
    check("rst_valid", 64'(bus.valid_out), 64'd0);
    check("rst_level", 64'(bus.level_out), 64'd0);
    check("rst_count", 64'(bus.spawn_count_out), 64'd0);
    cycle_idle(1);
    frames(29, 10);
    ft_cycle();
    check("restart_valid", 64'(bus.valid_out), 64'b0001);
    check("restart_dir", 64'(bus.direction_out[1:0]), 64'b01);
    check("restart_speed", 64'(bus.speed_out[2:0]), 64'd2);
    check("restart_inv", 64'(bus.inversed_out[0]), 64'd0);
    cycle_idle(9);

    // Slot occupancy table: fill, block, retire with cooldown, next_out ordering.
    rst = 1'b1;
    drive_idle();
    step();
    rst = 1'b0;
    cycle_idle(1);
    for (int r = 0; r < 9; r++) begin
      frames(rows[r].frames, 10);
      check($sformatf("row%0d_valid", r), 64'(bus.valid_out), 64'(rows[r].exp_valid));
      check($sformatf("row%0d_next", r), 64'(bus.next_out), 64'(rows[r].exp_next));
      if (rows[r].hit != '0) begin
        pulse_hit(rows[r].hit);
        check($sformatf("row%0d_valid_after_hit", r), 64'(bus.valid_out), 64'(rows[r].exp_valid_after));
        check($sformatf("row%0d_next_after_hit", r), 64'(bus.next_out), 64'(rows[r].exp_next_after));
      end
    end

    // Level ramp: retire every arrow each frame so spawns land on the gap schedule.
    fidx = 0;
    prev = int'(bus.spawn_count_out);
    for (int i = 0; i < 64; i++) sf[i] = 0;
    while (bus.spawn_count_out < 8'd41 && fidx < 2000) begin
      fidx++;
      ft_cycle();
      c = int'(bus.spawn_count_out);
      if (c != prev && c < 64) begin
        sf[c] = fidx;
        if (c == 9)  check("gap_level1", 64'(sf[9] - sf[8]), 64'd26);
        if (c == 16) check("level_after_16", 64'(bus.level_out), 64'd2);
        if (c == 17) begin
          check("speed_level2", 64'(bus.speed_out[2:0]), 64'd4);
          check("gap_level2", 64'(sf[17] - sf[16]), 64'd22);
        end
        if (c == 40) check("level_after_40", 64'(bus.level_out), 64'd5);
        if (c == 41) begin
          check("speed_level5", 64'(bus.speed_out[2:0]), 64'd7);
          check("level_sat", 64'(bus.level_out), 64'd5);
          check("gap_level5", 64'(sf[41] - sf[40]), 64'd10);
        end
      end
      prev = c;
      cycle_idle(1);
      for (int i = 0; i < NA; i++) mm[i] = m_act[i];
      pulse_hit(mm);
      cycle_idle(5);
    end
    if (bus.spawn_count_out < 8'd41) check("ramp_timeout", 64'(bus.spawn_count_out), 64'd41);

    // Randomized run against the model.
    rst = 1'b1;
    drive_idle();
    step();
    rst = 1'b0;
    bus.start_in = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      bus.game_over_in = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) bus.start_in = ~bus.start_in;
      bus.is_hit_in = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 5) == 0) begin
        bus.hcount_in = 11'd0;
        bus.vcount_in = 10'd0;
      end else begin
        drive_idle();
      end
      step();
    end
    rst = 1'b0;
    bus.game_over_in = 1'b0;
    bus.is_hit_in = '0;
    cycle_idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
